// File: rtl/wb_arb_pkg.sv
// Shared widths and the queued write-back entry type for the write-back arbiter.
package wb_arb_pkg;

  localparam int unsigned WB_DEPTH  = 4;
  localparam int unsigned WB_ADDR_W = 5;
  localparam int unsigned WB_DATA_W = 32;

  // One pending register-file write.
  typedef struct packed {
    logic [WB_ADDR_W-1:0] rd;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_ordered_queue.sv
// Dual-push, single-pop circular buffer holding pending register writes in program order.
module wb_ordered_queue
  import wb_arb_pkg::*;
#(
  parameter int unsigned DEPTH = WB_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          push1,
  input  wb_entry_t                     entry1,
  input  logic                          push2,
  input  wb_entry_t                     entry2,
  input  logic                          pop,
  output wb_entry_t                     head_entry,
  output logic [$clog2(DEPTH)-1:0]      head,
  output logic [$clog2(DEPTH):0]        count,
  output wb_entry_t [DEPTH-1:0]         entries
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] lane2_idx;
  logic [1:0]       n_push;

  // Lane 2 lands right behind lane 1, or at tail when lane 1 was not enqueued.
  always_comb begin
    n_push    = 2'(push1) + 2'(push2);
    lane2_idx = tail + PTR_W'(push1);
  end

  // Pointer and occupancy state; flush empties the queue ahead of any push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(pop);
      tail  <= tail + PTR_W'(n_push);
      count <= count + CNT_W'(n_push) - CNT_W'(pop);
    end
  end

  // Entry storage; contents beyond the occupied range are don't-care.
  always_ff @(posedge clk) begin
    if (!flush) begin
      if (push1) entries[tail]      <= entry1;
      if (push2) entries[lane2_idx] <= entry2;
    end
  end

  assign head_entry = entries[head];

endmodule

// File: rtl/regfile_writeback_arbiter.sv
// Merges two datapath result buses into one ordered register-file write port with forwarding lookups.
module regfile_writeback_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned DEPTH  = WB_DEPTH,
  parameter int unsigned ADDR_W = WB_ADDR_W,
  parameter int unsigned DATA_W = WB_DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     wb1_valid,
  input  logic [ADDR_W-1:0]        wb1_rd,
  input  logic [DATA_W-1:0]        wb1_data,
  input  logic                     wb2_valid,
  input  logic [ADDR_W-1:0]        wb2_rd,
  input  logic [DATA_W-1:0]        wb2_data,
  output logic                     wb_ready,
  input  logic                     rf_busy,
  output logic                     rf_we,
  output logic [ADDR_W-1:0]        rf_waddr,
  output logic [DATA_W-1:0]        rf_wdata,
  input  logic [ADDR_W-1:0]        q0_addr,
  output logic                     q0_hit,
  output logic [DATA_W-1:0]        q0_data,
  input  logic [ADDR_W-1:0]        q1_addr,
  output logic                     q1_hit,
  output logic [DATA_W-1:0]        q1_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic                  push1;
  logic                  push2;
  wb_entry_t             entry1;
  wb_entry_t             entry2;
  wb_entry_t             head_entry;
  logic [PTR_W-1:0]      head;
  wb_entry_t [DEPTH-1:0] entries;

  // Ready looks only at registered occupancy; x0 writes are accepted but dropped.
  always_comb begin
    wb_ready = count <= CNT_W'(DEPTH - 2);
    push1    = wb1_valid && wb_ready && (wb1_rd != '0);
    push2    = wb2_valid && wb_ready && (wb2_rd != '0);
    entry1   = '{rd: wb1_rd, data: wb1_data};
    entry2   = '{rd: wb2_rd, data: wb2_data};
  end

  // Retire the head entry straight to the register file; flush suppresses the write.
  always_comb begin
    rf_we    = (count != '0) && !rf_busy && !flush;
    rf_waddr = (count != '0) ? head_entry.rd   : '0;
    rf_wdata = (count != '0) ? head_entry.data : '0;
  end

  wb_ordered_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .push1      (push1),
    .entry1     (entry1),
    .push2      (push2),
    .entry2     (entry2),
    .pop        (rf_we),
    .head_entry (head_entry),
    .head       (head),
    .count      (count),
    .entries    (entries)
  );

  // Walk occupied entries oldest to youngest so the youngest match is left standing.
  function automatic void lookup(input  logic [ADDR_W-1:0] addr,
                                 output logic              hit,
                                 output logic [DATA_W-1:0] data);
    logic [PTR_W-1:0] idx;
    hit  = 1'b0;
    data = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if ((CNT_W'(i) < count) && (addr != '0) && (entries[idx].rd == addr)) begin
        hit  = 1'b1;
        data = entries[idx].data;
      end
    end
  endfunction

  // Two independent forwarding ports for decode.
  always_comb begin
    lookup(q0_addr, q0_hit, q0_data);
    lookup(q1_addr, q1_hit, q1_data);
  end

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Randomized and directed bench for regfile_writeback_arbiter against a queue-based reference model.
module tb_regfile_writeback_arbiter;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 32;

  typedef struct {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } ent_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              wb1_valid, wb2_valid;
  logic [ADDR_W-1:0] wb1_rd, wb2_rd;
  logic [DATA_W-1:0] wb1_data, wb2_data;
  logic              wb_ready;
  logic              rf_busy;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [ADDR_W-1:0] q0_addr, q1_addr;
  logic              q0_hit, q1_hit;
  logic [DATA_W-1:0] q0_data, q1_data;
  logic [$clog2(DEPTH):0] count;

  int n_vec = 0;
  int n_err = 0;
  ent_t mq[$];

  regfile_writeback_arbiter #(
    .DEPTH (DEPTH), .ADDR_W (ADDR_W), .DATA_W (DATA_W)
  ) dut (
    .clk (clk), .rst (rst), .flush (flush),
    .wb1_valid (wb1_valid), .wb1_rd (wb1_rd), .wb1_data (wb1_data),
    .wb2_valid (wb2_valid), .wb2_rd (wb2_rd), .wb2_data (wb2_data),
    .wb_ready (wb_ready), .rf_busy (rf_busy),
    .rf_we (rf_we), .rf_waddr (rf_waddr), .rf_wdata (rf_wdata),
    .q0_addr (q0_addr), .q0_hit (q0_hit), .q0_data (q0_data),
    .q1_addr (q1_addr), .q1_hit (q1_hit), .q1_data (q1_data),
    .count (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Youngest queued value for addr; x0 never forwards.
  function automatic void model_lookup(input logic [ADDR_W-1:0] addr,
                                       output logic hit, output logic [DATA_W-1:0] data);
    hit  = 1'b0;
    data = '0;
    if (addr != '0) begin
      for (int i = mq.size() - 1; i >= 0; i--) begin
        if (mq[i].rd == addr) begin
          hit  = 1'b1;
          data = mq[i].data;
          break;
        end
      end
    end
  endfunction

  task automatic compare_all();
    logic h; logic [DATA_W-1:0] d;
    int sz = mq.size();
    check("count", 64'(count), 64'(sz));
    check("wb_ready", 64'(wb_ready), 64'((DEPTH - sz) >= 2));
    check("rf_we", 64'(rf_we), 64'(sz != 0 && !rf_busy && !flush));
    check("rf_waddr", 64'(rf_waddr), (sz != 0) ? 64'(mq[0].rd) : 64'd0);
    check("rf_wdata", 64'(rf_wdata), (sz != 0) ? 64'(mq[0].data) : 64'd0);
    model_lookup(q0_addr, h, d);
    check("q0_hit", 64'(q0_hit), 64'(h));
    check("q0_data", 64'(q0_data), 64'(d));
    model_lookup(q1_addr, h, d);
    check("q1_hit", 64'(q1_hit), 64'(h));
    check("q1_data", 64'(q1_data), 64'(d));
  endtask

  task automatic model_update();
    bit rdy = (DEPTH - mq.size()) >= 2;
    bit pop = (mq.size() != 0) && !rf_busy;
    ent_t e;
    if (flush) begin
      mq.delete();
    end else begin
      if (pop) void'(mq.pop_front());
      if (rdy && wb1_valid && wb1_rd != '0) begin e.rd = wb1_rd; e.data = wb1_data; mq.push_back(e); end
      if (rdy && wb2_valid && wb2_rd != '0) begin e.rd = wb2_rd; e.data = wb2_data; mq.push_back(e); end
    end
  endtask

  // Inputs are set by the caller one unit after a rising edge; compare, then clock the model.
  task automatic step();
    #2;
    compare_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    flush = 0; wb1_valid = 0; wb2_valid = 0; rf_busy = 0;
    wb1_rd = '0; wb2_rd = '0; wb1_data = '0; wb2_data = '0;
  endtask

  task automatic drive(input bit v1, input logic [ADDR_W-1:0] r1, input logic [DATA_W-1:0] d1,
                       input bit v2, input logic [ADDR_W-1:0] r2, input logic [DATA_W-1:0] d2);
    wb1_valid = v1; wb1_rd = r1; wb1_data = d1;
    wb2_valid = v2; wb2_rd = r2; wb2_data = d2;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    q0_addr = 5'd5; q1_addr = 5'd7;
    // Reset state.
    #3;
    check("rst_rf_we", 64'(rf_we), 64'd0);
    check("rst_ready", 64'(wb_ready), 64'd1);
    check("rst_count", 64'(count), 64'd0);
    check("rst_q0_hit", 64'(q0_hit), 64'd0);
    check("rst_q0_data", 64'(q0_data), 64'd0);
    check("rst_waddr", 64'(rf_waddr), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    step();

    // Same-cycle pair to x5: older value written first, younger forwarded.
    drive(1, 5'd5, 32'h11, 1, 5'd5, 32'h22);
    step();
    idle();
    #1;
    check("pair_first_addr", 64'(rf_waddr), 64'd5);
    check("pair_first_data", 64'(rf_wdata), 64'h11);
    check("pair_fwd", 64'(q0_data), 64'h22);
    step();
    #1;
    check("pair_second_data", 64'(rf_wdata), 64'h22);
    step();
    step();

    // Fill while busy; third pair is dropped; then drain in order.
    rf_busy = 1;
    drive(1, 5'd1, 32'hA1, 1, 5'd2, 32'hA2); step();
    drive(1, 5'd3, 32'hA3, 1, 5'd4, 32'hA4); step();
    drive(1, 5'd6, 32'hA6, 1, 5'd7, 32'hA7);
    #1;
    check("full_count", 64'(count), 64'd4);
    check("full_ready", 64'(wb_ready), 64'd0);
    step();
    drive(0, 0, 0, 0, 0, 0);
    rf_busy = 0;
    for (int i = 0; i < 5; i++) step();

    // Count 3 with a pop and an offered push: push ignored, ready low until count <= 2.
    rf_busy = 1;
    drive(1, 5'd1, 32'hB1, 1, 5'd2, 32'hB2); step();
    drive(1, 5'd3, 32'hB3, 0, 0, 0); step();
    rf_busy = 0;
    drive(1, 5'd9, 32'hB9, 0, 0, 0);
    #1;
    check("c3_ready", 64'(wb_ready), 64'd0);
    step();
    idle();
    for (int i = 0; i < 3; i++) step();

    // x0 on lane 1 is dropped; only x7 is queued.
    q0_addr = 5'd0; q1_addr = 5'd7;
    rf_busy = 1;
    drive(1, 5'd0, 32'hC0, 1, 5'd7, 32'hC7); step();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    check("x0_count", 64'(count), 64'd1);
    check("x0_q0_hit", 64'(q0_hit), 64'd0);
    check("x7_q1_data", 64'(q1_data), 64'hC7);
    step();
    rf_busy = 0;
    step();

    // Flush with a valid push at count 2.
    rf_busy = 1;
    drive(1, 5'd3, 32'hD3, 1, 5'd4, 32'hD4); step();
    rf_busy = 0; flush = 1;
    drive(1, 5'd5, 32'hD5, 1, 5'd6, 32'hD6);
    step();
    idle();
    #1;
    check("flush_count", 64'(count), 64'd0);
    step();

    // Reset mid-drain: write enable drops immediately.
    rf_busy = 1;
    drive(1, 5'd1, 32'hE1, 1, 5'd2, 32'hE2); step();
    idle(); step();
    rst = 1'b1;
    #1;
    check("rst_mid_we", 64'(rf_we), 64'd0);
    check("rst_mid_count", 64'(count), 64'd0);
    mq.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    step();

    // Randomized traffic on a narrow register range so forwarding collisions occur.
    for (int n = 0; n < 2000; n++) begin
      flush     = ($urandom_range(0, 99) < 3);
      rf_busy   = ($urandom_range(0, 99) < 30);
      wb1_valid = $urandom_range(0, 1) != 0;
      wb2_valid = $urandom_range(0, 1) != 0;
      wb1_rd    = 5'($urandom_range(0, 7));
      wb2_rd    = 5'($urandom_range(0, 7));
      wb1_data  = $urandom;
      wb2_data  = $urandom;
      q0_addr   = 5'($urandom_range(0, 7));
      q1_addr   = 5'($urandom_range(0, 7));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
